// File: rtl/fetch_ctrl_pkg.sv
// Shared types for fetch misprediction recovery: FSM states, predictor
// update entries and the oldest-lane picker.
package fetch_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_ENTRIES     = 32;
    localparam int unsigned DEF_INDEX_WIDTH = $clog2(DEF_ENTRIES);
    localparam int unsigned DEF_GHIST_WIDTH = DEF_INDEX_WIDTH + 3;
    localparam int unsigned NUM_LANES       = 3;
    localparam int unsigned LANE_IDX_W      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic                       is_jalr;
        logic [DEF_DATA_WIDTH-1:0]  pc;
        logic [DEF_DATA_WIDTH-1:0]  target;
        logic [DEF_GHIST_WIDTH-1:0] ghist;
    } upd_entry_t;

    // Lowest set index of a lane mask (lane 0 is oldest); 0 when empty.
    function automatic logic [LANE_IDX_W-1:0] oldest_lane(input logic [NUM_LANES-1:0] mask);
        oldest_lane = '0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                oldest_lane = LANE_IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/pred_update_fifo.sv
// Show-ahead predictor update FIFO: up to NUM_LANES pushes per cycle in lane
// order, one pop per cycle; pushes beyond free space are dropped and counted.
module pred_update_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LANES-1:0]          push_valid,
    input  upd_entry_t [NUM_LANES-1:0]    push_data,
    input  logic                          pop,
    output logic                          head_valid,
    output upd_entry_t                    head_data,
    output logic [LANE_IDX_W-1:0]         accepted_cnt_c,
    output logic [LANE_IDX_W-1:0]         drop_cnt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = (CNT_W > LANE_IDX_W) ? CNT_W : LANE_IDX_W;

    upd_entry_t                        mem [DEPTH];
    logic [PTR_W-1:0]                  wr_ptr;
    logic [PTR_W-1:0]                  rd_ptr;
    logic [CNT_W-1:0]                  count;

    logic                              pop_c;
    logic [SUM_W-1:0]                  free_c;
    logic [SUM_W-1:0]                  slot_c;
    logic [SUM_W-1:0]                  accepted_c;
    logic [NUM_LANES-1:0]              lane_we_c;
    logic [NUM_LANES-1:0][PTR_W-1:0]   lane_idx_c;

    // A pop frees its slot in the same cycle; valid lanes take consecutive slots.
    always_comb begin
        pop_c      = pop && (count != '0);
        free_c     = SUM_W'(DEPTH) - SUM_W'(count) + SUM_W'(pop_c);
        slot_c     = '0;
        lane_we_c  = '0;
        lane_idx_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            lane_idx_c[i] = wr_ptr + PTR_W'(slot_c);
            if (push_valid[i]) begin
                lane_we_c[i] = (slot_c < free_c);
                slot_c       = slot_c + SUM_W'(1);
            end
        end
        accepted_c     = (slot_c < free_c) ? slot_c : free_c;
        accepted_cnt_c = LANE_IDX_W'(accepted_c);
        drop_cnt_c     = LANE_IDX_W'(slot_c - accepted_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                mem[j] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (lane_we_c[i]) begin
                    mem[lane_idx_c[i]] <= push_data[i];
                end
            end
            wr_ptr <= wr_ptr + PTR_W'(accepted_c);
            rd_ptr <= rd_ptr + PTR_W'(pop_c);
            count  <= CNT_W'(SUM_W'(count) + accepted_c - SUM_W'(pop_c));
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/fetch_recovery_ctrl.sv
// Fetch misprediction recovery: redirect/flush of the oldest mispredicting
// lane, decode hold until refill, and serialised predictor updates.
module fetch_recovery_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int unsigned ENTRIES          = DEF_ENTRIES,
    parameter int unsigned BUFFER_DEPTH     = 16,
    parameter int unsigned UPD_FIFO_DEPTH   = 4,
    parameter int unsigned REFILL_THRESHOLD = 3,
    parameter int unsigned REFILL_TIMEOUT   = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2:0]                        misprediction_i,
    input  logic [2:0]                        update_valid_i,
    input  logic [2:0]                        is_jalr_i,
    input  logic [DATA_WIDTH-1:0]             pc_at_prediction_i_0,
    input  logic [DATA_WIDTH-1:0]             pc_at_prediction_i_1,
    input  logic [DATA_WIDTH-1:0]             pc_at_prediction_i_2,
    input  logic [DATA_WIDTH-1:0]             correct_pc_i_0,
    input  logic [DATA_WIDTH-1:0]             correct_pc_i_1,
    input  logic [DATA_WIDTH-1:0]             correct_pc_i_2,
    input  logic [$clog2(ENTRIES)+2:0]        update_global_history_0,
    input  logic [$clog2(ENTRIES)+2:0]        update_global_history_1,
    input  logic [$clog2(ENTRIES)+2:0]        update_global_history_2,
    input  logic [$clog2(BUFFER_DEPTH):0]     occupancy_i,
    output logic                              redirect_valid_o,
    output logic [DATA_WIDTH-1:0]             redirect_pc_o,
    output logic                              flush_o,
    output logic                              decode_hold_o,
    output logic                              upd_valid_o,
    input  logic                              upd_ready_i,
    output logic                              upd_is_jalr_o,
    output logic [DATA_WIDTH-1:0]             upd_pc_o,
    output logic [DATA_WIDTH-1:0]             upd_target_o,
    output logic [$clog2(ENTRIES)+2:0]        upd_ghist_o,
    output logic [7:0]                        upd_drop_cnt_o,
    output logic [1:0]                        state_o
);

    localparam int unsigned OCC_W  = $clog2(BUFFER_DEPTH) + 1;
    localparam int unsigned RCNT_W = $clog2(REFILL_TIMEOUT + 1);

    fetch_state_e                  state;
    logic [RCNT_W-1:0]             refill_cnt;

    logic                          any_mis_c;
    logic [LANE_IDX_W-1:0]         oldest_c;
    logic [NUM_LANES-1:0]          elig_c;
    upd_entry_t [NUM_LANES-1:0]    push_data_c;
    logic [DATA_WIDTH-1:0]         sel_pc_c;
    logic                          refill_done_c;
    logic [8:0]                    drop_sum_c;

    logic                          fifo_valid;
    upd_entry_t                    fifo_head;
    logic [LANE_IDX_W-1:0]         fifo_acc_c;
    logic [LANE_IDX_W-1:0]         fifo_drop_c;

    // Lanes younger than the oldest mispredict are wrong-path and never pushed.
    always_comb begin
        any_mis_c = |misprediction_i;
        oldest_c  = oldest_lane(misprediction_i);
        elig_c    = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            elig_c[i] = update_valid_i[i] && (!any_mis_c || (LANE_IDX_W'(i) <= oldest_c));
        end
        push_data_c[0] = '{is_jalr: is_jalr_i[0], pc: pc_at_prediction_i_0,
                           target: correct_pc_i_0, ghist: update_global_history_0};
        push_data_c[1] = '{is_jalr: is_jalr_i[1], pc: pc_at_prediction_i_1,
                           target: correct_pc_i_1, ghist: update_global_history_1};
        push_data_c[2] = '{is_jalr: is_jalr_i[2], pc: pc_at_prediction_i_2,
                           target: correct_pc_i_2, ghist: update_global_history_2};
        case (oldest_c)
            2'd0:    sel_pc_c = correct_pc_i_0;
            2'd1:    sel_pc_c = correct_pc_i_1;
            default: sel_pc_c = correct_pc_i_2;
        endcase
        refill_done_c = (occupancy_i >= OCC_W'(REFILL_THRESHOLD)) ||
                        (refill_cnt == RCNT_W'(REFILL_TIMEOUT - 1));
        drop_sum_c    = {1'b0, upd_drop_cnt_o} + 9'(fifo_drop_c);
    end

    pred_update_fifo #(
        .DEPTH          (UPD_FIFO_DEPTH)
    ) u_upd_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_valid     (elig_c),
        .push_data      (push_data_c),
        .pop            (upd_valid_o & upd_ready_i),
        .head_valid     (fifo_valid),
        .head_data      (fifo_head),
        .accepted_cnt_c (fifo_acc_c),
        .drop_cnt_c     (fifo_drop_c)
    );

    // Recovery FSM; a new mispredict in any state restarts at FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            refill_cnt       <= '0;
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
            redirect_pc_o    <= '0;
            decode_hold_o    <= 1'b0;
            upd_drop_cnt_o   <= '0;
        end else begin
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
            upd_drop_cnt_o   <= drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
            if (any_mis_c) begin
                state            <= FLUSH;
                redirect_valid_o <= 1'b1;
                flush_o          <= 1'b1;
                redirect_pc_o    <= sel_pc_c;
                decode_hold_o    <= 1'b1;
            end else begin
                case (state)
                    FLUSH: begin
                        state         <= REFILL;
                        refill_cnt    <= '0;
                        decode_hold_o <= 1'b1;
                    end
                    REFILL: begin
                        if (refill_done_c) begin
                            state         <= IDLE;
                            decode_hold_o <= 1'b0;
                        end else begin
                            refill_cnt    <= refill_cnt + RCNT_W'(1);
                            decode_hold_o <= 1'b1;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        decode_hold_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Every eligible lane is either accepted or dropped.
    assert property (@(posedge clk) disable iff (reset)
        (3'(fifo_acc_c) + 3'(fifo_drop_c)) == 3'($countones(elig_c)));

    assign state_o       = state;
    assign upd_valid_o   = fifo_valid;
    assign upd_is_jalr_o = fifo_head.is_jalr;
    assign upd_pc_o      = fifo_head.pc;
    assign upd_target_o  = fifo_head.target;
    assign upd_ghist_o   = fifo_head.ghist;

endmodule

// File: tb/tb_fetch_recovery_ctrl.sv
// Directed bench for fetch_recovery_ctrl: a vector table for the main flow
// plus hand sequences for timeout, restart, FIFO overflow and reset abort.
module tb_fetch_recovery_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned GW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    misprediction_i, update_valid_i, is_jalr_i;
    logic [DW-1:0] correct_pc_i_0, correct_pc_i_1, correct_pc_i_2;
    logic [4:0]    occupancy_i;
    logic          upd_ready_i;
    logic          redirect_valid_o, flush_o, decode_hold_o, upd_valid_o, upd_is_jalr_o;
    logic [DW-1:0] redirect_pc_o, upd_pc_o, upd_target_o;
    logic [GW-1:0] upd_ghist_o;
    logic [7:0]    upd_drop_cnt_o;
    logic [1:0]    state_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    fetch_recovery_ctrl dut (
        .clk                     (clk),
        .reset                   (reset),
        .misprediction_i         (misprediction_i),
        .update_valid_i          (update_valid_i),
        .is_jalr_i               (is_jalr_i),
        .pc_at_prediction_i_0    (32'h0000_1000),
        .pc_at_prediction_i_1    (32'h0000_1004),
        .pc_at_prediction_i_2    (32'h0000_1008),
        .correct_pc_i_0          (correct_pc_i_0),
        .correct_pc_i_1          (correct_pc_i_1),
        .correct_pc_i_2          (correct_pc_i_2),
        .update_global_history_0 (8'h10),
        .update_global_history_1 (8'h11),
        .update_global_history_2 (8'h12),
        .occupancy_i             (occupancy_i),
        .redirect_valid_o        (redirect_valid_o),
        .redirect_pc_o           (redirect_pc_o),
        .flush_o                 (flush_o),
        .decode_hold_o           (decode_hold_o),
        .upd_valid_o             (upd_valid_o),
        .upd_ready_i             (upd_ready_i),
        .upd_is_jalr_o           (upd_is_jalr_o),
        .upd_pc_o                (upd_pc_o),
        .upd_target_o            (upd_target_o),
        .upd_ghist_o             (upd_ghist_o),
        .upd_drop_cnt_o          (upd_drop_cnt_o),
        .state_o                 (state_o)
    );

    typedef struct {
        logic [2:0]  mis;
        logic [2:0]  uv;
        logic [31:0] base;
        logic [4:0]  occ;
        logic        rdy;
        logic        e_rv;
        logic        e_fl;
        logic [31:0] e_rpc;
        logic        e_hold;
        logic [1:0]  e_st;
        logic        e_uvo;
        logic [31:0] e_upc;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Lane l receives correct_pc = base + 0x10*l so the picked lane is visible.
    task automatic drive(input logic [2:0] mis, input logic [2:0] uv, input logic [2:0] jalr,
                         input logic [31:0] base, input logic [4:0] occ, input logic rdy);
        misprediction_i = mis;
        update_valid_i  = uv;
        is_jalr_i       = jalr;
        correct_pc_i_0  = base;
        correct_pc_i_1  = base + 32'h10;
        correct_pc_i_2  = base + 32'h20;
        occupancy_i     = occ;
        upd_ready_i     = rdy;
    endtask

    task automatic cyc(input logic [2:0] mis, input logic [2:0] uv, input logic [2:0] jalr,
                       input logic [31:0] base, input logic [4:0] occ, input logic rdy);
        drive(mis, uv, jalr, base, occ, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          mis     uv      base          occ    rdy   rv    fl    rpc           hold  st     uvo   upc           drop
        tbl[0]  = '{3'b110, 3'b000, 32'h0000_00F0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 2'd1, 1'b0, 32'h0,         8'd0};
        tbl[1]  = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[2]  = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[3]  = '{3'b000, 3'b000, 32'h0,         5'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[4]  = '{3'b000, 3'b000, 32'h0,         5'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[5]  = '{3'b000, 3'b000, 32'h0,         5'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 2'd0, 1'b0, 32'h0,         8'd0};
        tbl[6]  = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 2'd0, 1'b0, 32'h0,         8'd0};
        tbl[7]  = '{3'b100, 3'b000, 32'h0000_02E0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 2'd1, 1'b0, 32'h0,         8'd0};
        tbl[8]  = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[9]  = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[10] = '{3'b001, 3'b000, 32'h0000_0200, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 2'd1, 1'b0, 32'h0,         8'd0};
        tbl[11] = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 2'd2, 1'b0, 32'h0,         8'd0};
        tbl[12] = '{3'b000, 3'b000, 32'h0,         5'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 2'd0, 1'b0, 32'h0,         8'd0};
        tbl[13] = '{3'b010, 3'b111, 32'h0000_03F0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b1, 2'd1, 1'b1, 32'h0000_1000, 8'd0};
        tbl[14] = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b1, 2'd2, 1'b1, 32'h0000_1004, 8'd0};
        tbl[15] = '{3'b000, 3'b000, 32'h0,         5'd3, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 2'd0, 1'b0, 32'h0,         8'd0};
        tbl[16] = '{3'b000, 3'b101, 32'h0,         5'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 2'd0, 1'b1, 32'h0000_1000, 8'd0};
        tbl[17] = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 2'd0, 1'b1, 32'h0000_1008, 8'd0};
        tbl[18] = '{3'b000, 3'b000, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 2'd0, 1'b0, 32'h0,         8'd0};

        reset = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset rv",    32'(redirect_valid_o), 32'd0);
        check("reset flush", 32'(flush_o),          32'd0);
        check("reset rpc",   redirect_pc_o,         32'd0);
        check("reset hold",  32'(decode_hold_o),    32'd0);
        check("reset state", 32'(state_o),          32'd0);
        check("reset uvo",   32'(upd_valid_o),      32'd0);
        check("reset drop",  32'(upd_drop_cnt_o),   32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].mis, tbl[i].uv, 3'b000, tbl[i].base, tbl[i].occ, tbl[i].rdy);
            check($sformatf("row%0d rv", i),    32'(redirect_valid_o), 32'(tbl[i].e_rv));
            check($sformatf("row%0d flush", i), 32'(flush_o),          32'(tbl[i].e_fl));
            check($sformatf("row%0d rpc", i),   redirect_pc_o,         tbl[i].e_rpc);
            check($sformatf("row%0d hold", i),  32'(decode_hold_o),    32'(tbl[i].e_hold));
            check($sformatf("row%0d state", i), 32'(state_o),          32'(tbl[i].e_st));
            check($sformatf("row%0d uvo", i),   32'(upd_valid_o),      32'(tbl[i].e_uvo));
            if (tbl[i].e_uvo) begin
                check($sformatf("row%0d upc", i), upd_pc_o, tbl[i].e_upc);
            end
            check($sformatf("row%0d drop", i),  32'(upd_drop_cnt_o),   32'(tbl[i].e_drop));
        end

        // Restart mid-REFILL, then 15 REFILL cycles to timeout.
        cyc(3'b001, 3'b000, 3'b000, 32'h0000_0500, 5'd0, 1'b0);
        check("to first rpc", redirect_pc_o, 32'h0000_0500);
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
        check("to refill", 32'(state_o), 32'd2);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
            check($sformatf("to pre%0d state", i), 32'(state_o), 32'd2);
        end
        cyc(3'b010, 3'b000, 3'b000, 32'h0000_05F0, 5'd0, 1'b0);
        check("restart rv",    32'(redirect_valid_o), 32'd1);
        check("restart rpc",   redirect_pc_o,         32'h0000_0600);
        check("restart state", 32'(state_o),          32'd1);
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
        check("restart refill", 32'(state_o), 32'd2);
        for (int i = 0; i < 14; i++) begin
            cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
            check($sformatf("to cnt%0d state", i), 32'(state_o),       32'd2);
            check($sformatf("to cnt%0d hold", i),  32'(decode_hold_o), 32'd1);
        end
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
        check("timeout state", 32'(state_o),       32'd0);
        check("timeout hold",  32'(decode_hold_o), 32'd0);

        // Fill the FIFO, overflow it, then overflow while popping.
        cyc(3'b000, 3'b111, 3'b101, 32'h0000_0700, 5'd0, 1'b0);
        check("fill uvo",    32'(upd_valid_o),   32'd1);
        check("fill pc",     upd_pc_o,           32'h0000_1000);
        check("fill jalr",   32'(upd_is_jalr_o), 32'd1);
        check("fill target", upd_target_o,       32'h0000_0700);
        check("fill ghist",  32'(upd_ghist_o),   32'h10);
        cyc(3'b000, 3'b001, 3'b000, 32'h0, 5'd0, 1'b0);
        check("fill4 drop", 32'(upd_drop_cnt_o), 32'd0);
        cyc(3'b000, 3'b111, 3'b000, 32'h0, 5'd0, 1'b0);
        check("full drop", 32'(upd_drop_cnt_o), 32'd3);
        check("full head", upd_pc_o,            32'h0000_1000);
        cyc(3'b000, 3'b111, 3'b000, 32'h0, 5'd0, 1'b1);
        check("popfull drop", 32'(upd_drop_cnt_o), 32'd5);
        check("popfull head", upd_pc_o,            32'h0000_1004);
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b1);
        check("drain0", upd_pc_o, 32'h0000_1008);
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b1);
        check("drain1", upd_pc_o, 32'h0000_1000);
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b1);
        check("drain2 uvo", 32'(upd_valid_o), 32'd1);
        check("drain2",     upd_pc_o,         32'h0000_1000);
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b1);
        check("drained uvo", 32'(upd_valid_o), 32'd0);

        for (int i = 0; i < 100; i++) begin
            cyc(3'b000, 3'b111, 3'b000, 32'h0, 5'd0, 1'b0);
        end
        check("drop saturate", 32'(upd_drop_cnt_o), 32'd255);

        // Reset with a mispredict present aborts without a redirect.
        reset = 1'b1;
        cyc(3'b001, 3'b000, 3'b000, 32'h0000_0800, 5'd0, 1'b0);
        check("abort rv",    32'(redirect_valid_o), 32'd0);
        check("abort flush", 32'(flush_o),          32'd0);
        check("abort rpc",   redirect_pc_o,         32'd0);
        check("abort state", 32'(state_o),          32'd0);
        check("abort hold",  32'(decode_hold_o),    32'd0);
        check("abort uvo",   32'(upd_valid_o),      32'd0);
        check("abort upc",   upd_pc_o,              32'd0);
        check("abort drop",  32'(upd_drop_cnt_o),   32'd0);
        reset = 1'b0;
        cyc(3'b000, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0);
        check("post state", 32'(state_o),     32'd0);
        check("post uvo",   32'(upd_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
